// File: rtl/pc_pkg.sv
// Shared types and default vectors for the fetch PC sequencer and its return-address stack.
package pc_pkg;

  typedef enum logic [1:0] {BOOT, RUN, HALT} pc_state_t;

  typedef enum logic [2:0] {EXC, RET, BR, JMP, SEQ} pc_src_t;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0040_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h8000_0180;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push overwrites the oldest entry when full, pop on empty is a no-op.
// Updates land one clock after push/pop/clear; clear wins over push and pop.
module pc_ras
  import pc_pkg::*;
#(
  parameter int unsigned N         = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  logic [N-1:0] push_data,
  output logic [N-1:0] top,
  output logic         empty,
  output logic         full
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

  logic [N-1:0]  mem [RAS_DEPTH];
  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_dec;
  logic [CW-1:0] cnt;

  // ptr is the next free slot, so the top lives one below it.
  assign ptr_dec = ptr - PW'(1);
  assign top     = mem[ptr_dec];
  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(RAS_DEPTH));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RAS_DEPTH; i++) mem[i] <= '0;
      ptr <= '0;
      cnt <= '0;
    end else if (clear) begin
      ptr <= '0;
      cnt <= '0;
    end else if (push && pop && !empty) begin
      mem[ptr_dec] <= push_data;
    end else if (push) begin
      mem[ptr] <= push_data;
      ptr      <= ptr + PW'(1);
      if (!full) cnt <= cnt + CW'(1);
    end else if (pop && !empty) begin
      ptr <= ptr_dec;
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: priority next-PC select, BOOT/RUN/HALT sequencing, optional RAS under PC_SEQ_RAS_EN.
// Redirects appear on PCValue one clock after the request; enable=0 stalls everything except exc_req.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned  N            = 32,
  parameter logic [N-1:0] RESET_VECTOR = N'(DEF_RESET_VECTOR),
  parameter logic [N-1:0] EXC_VECTOR   = N'(DEF_EXC_VECTOR),
  parameter int unsigned  RAS_DEPTH    = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         halt,
  input  logic         exc_req,
  input  logic         branch_taken,
  input  logic [N-1:0] branch_target,
  input  logic         jump,
  input  logic [N-1:0] jump_target,
  input  logic         call,
  input  logic         ret,
  output logic [N-1:0] PCValue,
  output logic [N-1:0] PCPlus4,
  output logic         pc_valid,
  output logic         misaligned,
  output logic         ras_empty,
  output logic         ras_full
);

  pc_state_t    state, state_nxt;
  pc_src_t      src;
  logic [N-1:0] pc, pc_nxt, target, ret_target;
  logic         mis, mis_nxt, redirect;
  logic         ras_push, ras_pop, ras_clear;

  assign PCValue    = pc;
  assign PCPlus4    = pc + N'(4);
  assign pc_valid   = (state == RUN);
  assign misaligned = mis;

`ifdef PC_SEQ_RAS_EN
  logic [N-1:0] ras_top;

  pc_ras #(
    .N        (N),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .reset    (reset),
    .push     (ras_push),
    .pop      (ras_pop),
    .clear    (ras_clear),
    .push_data(PCPlus4),
    .top      (ras_top),
    .empty    (ras_empty),
    .full     (ras_full)
  );

  assign ret_target = ras_empty ? jump_target : ras_top;
`else
  localparam int unsigned unused_depth = RAS_DEPTH;
  logic unused_ras;

  assign unused_ras = ^{call, ras_push, ras_pop, ras_clear};
  assign ret_target = jump_target;
  assign ras_empty  = 1'b1;
  assign ras_full   = 1'b0;
`endif

  always_comb begin
    src    = SEQ;
    target = PCPlus4;
    if (exc_req) begin
      src    = EXC;
      target = EXC_VECTOR;
    end else if (ret) begin
      src    = RET;
      target = ret_target;
    end else if (branch_taken) begin
      src    = BR;
      target = branch_target;
    end else if (jump) begin
      src    = JMP;
      target = jump_target;
    end
  end

  assign redirect = (src == RET) || (src == BR) || (src == JMP);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    mis_nxt   = mis;
    ras_push  = 1'b0;
    ras_pop   = 1'b0;
    ras_clear = 1'b0;
    case (state)
      BOOT: state_nxt = RUN;
      RUN: begin
        // exc_req acts even while stalled and overrides any RAS traffic.
        if (exc_req) begin
          pc_nxt    = EXC_VECTOR;
          ras_clear = 1'b1;
        end else if (enable) begin
          ras_push = call;
          ras_pop  = ret;
          if (redirect && (target[1:0] != 2'b00)) begin
            pc_nxt  = EXC_VECTOR;
            mis_nxt = 1'b1;
          end else begin
            pc_nxt = target;
          end
        end
        if (enable && halt) state_nxt = HALT;
      end
      HALT: begin
        if (exc_req) begin
          state_nxt = RUN;
          pc_nxt    = EXC_VECTOR;
          ras_clear = 1'b1;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= BOOT;
      pc    <= RESET_VECTOR;
      mis   <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      mis   <= mis_nxt;
    end
  end

endmodule
